// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl
//   Wraps a 1-clock dual-port BRAM with three registered read stages (which
//   advance only while rden is high) into a valid/ready streaming FIFO.
//   Upstream writes go straight to the BRAM. Reads are issued as soon as data
//   is resident, and three valid bits follow the BRAM read stages. The last
//   stage is captured into a small skid FIFO that feeds the downstream port.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   s_data/s_valid     upstream write stream; s_ready = BRAM not full
//   m_data/m_valid     downstream stream (skid FIFO head / not empty)
//   m_ready            downstream accept
//   ram_wrAddr/ram_datain/ram_wren   BRAM write port
//   ram_rdAddr/ram_rden              BRAM read address / pipeline advance
//   ram_dataout        BRAM final read stage register
//   fill_level         entries written to the BRAM but not yet issued for read
module bram_fifo_ctrl #(
  parameter int C_RAM_WIDTH  = 64,
  parameter int C_RAM_DEPTH  = 512,
  parameter int C_SKID_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [C_RAM_WIDTH-1:0]             s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [C_RAM_WIDTH-1:0]             m_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [$clog2(C_RAM_DEPTH)-1:0]     ram_wrAddr,
  output logic [C_RAM_WIDTH-1:0]             ram_datain,
  output logic                               ram_wren,
  output logic [$clog2(C_RAM_DEPTH)-1:0]     ram_rdAddr,
  output logic                               ram_rden,
  input  logic [C_RAM_WIDTH-1:0]             ram_dataout,
  output logic [$clog2(C_RAM_DEPTH+1)-1:0]   fill_level
);

  localparam int AW = $clog2(C_RAM_DEPTH);
  localparam int FW = $clog2(C_RAM_DEPTH + 1);
  localparam int SW = $clog2(C_SKID_DEPTH);
  localparam int CW = $clog2(C_SKID_DEPTH + 1);

  localparam logic [AW-1:0] PTR_LAST  = AW'(C_RAM_DEPTH - 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(C_RAM_DEPTH);
  localparam logic [SW-1:0] SKID_LAST = SW'(C_SKID_DEPTH - 1);
  localparam logic [CW-1:0] SKID_MAX  = CW'(C_SKID_DEPTH);

  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [FW-1:0]          fill;
  logic [2:0]             vld;

  logic [C_RAM_WIDTH-1:0] skid_mem [C_SKID_DEPTH];
  logic [SW-1:0]          skid_head;
  logic [SW-1:0]          skid_tail;
  logic [CW-1:0]          skid_cnt;

  logic ram_full;
  logic pending;
  logic wr;
  logic issue;
  logic rden;
  logic push;
  logic pop;
  logic skid_full;
  logic skid_empty;

  always_comb begin
    ram_full   = (fill == FILL_MAX);
    pending    = (fill != '0);
    wr         = s_valid & ~ram_full;
    skid_full  = (skid_cnt == SKID_MAX);
    skid_empty = (skid_cnt == '0);
    pop        = ~skid_empty & m_ready;
    // Stall the read pipeline only when the word in the last stage has
    // nowhere to go; a same-cycle pop frees a slot for it.
    rden       = (pending | (vld != '0)) & ~(vld[2] & skid_full & ~pop);
    issue      = rden & pending;
    // The last stage is overwritten on rden, so capture it on that same edge.
    push       = rden & vld[2];
  end

  assign s_ready    = ~ram_full;
  assign ram_wren   = wr;
  assign ram_wrAddr = wr_ptr;
  assign ram_datain = s_data;
  assign ram_rdAddr = rd_ptr;
  assign ram_rden   = rden;
  assign fill_level = fill;
  assign m_valid    = ~skid_empty;
  assign m_data     = skid_mem[skid_head];

  // BRAM pointers, fill tracking and read-stage valid shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      vld    <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
      end
      if (issue) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
      end
      case ({wr, issue})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
      if (rden) begin
        vld <= {vld[1:0], issue};
      end
    end
  end

  // Output skid FIFO (circular buffer, depth need not be a power of two)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < C_SKID_DEPTH; i++) begin
        skid_mem[i] <= '0;
      end
      skid_head <= '0;
      skid_tail <= '0;
      skid_cnt  <= '0;
    end else begin
      if (push) begin
        skid_mem[skid_tail] <= ram_dataout;
        skid_tail <= (skid_tail == SKID_LAST) ? '0 : skid_tail + SW'(1);
      end
      if (pop) begin
        skid_head <= (skid_head == SKID_LAST) ? '0 : skid_head + SW'(1);
      end
      case ({push, pop})
        2'b10:   skid_cnt <= skid_cnt + CW'(1);
        2'b01:   skid_cnt <= skid_cnt - CW'(1);
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl
//   Bench for bram_fifo_ctrl with a behavioural 3-stage BRAM attached.
//   Reference model: a queue of accepted words (expected output order) plus
//   write/issue counters that give expected addresses and fill level.
module tb_bram_fifo_ctrl;

  localparam int W     = 16;
  localparam int DEPTH = 5;
  localparam int SKID  = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW-1:0] ram_wrAddr;
  logic [W-1:0]  ram_datain;
  logic          ram_wren;
  logic [AW-1:0] ram_rdAddr;
  logic          ram_rden;
  logic [W-1:0]  ram_dataout;
  logic [FW-1:0] fill_level;

  always #5 clk = ~clk;

  bram_fifo_ctrl #(
    .C_RAM_WIDTH (W),
    .C_RAM_DEPTH (DEPTH),
    .C_SKID_DEPTH(SKID)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .ram_wrAddr (ram_wrAddr),
    .ram_datain (ram_datain),
    .ram_wren   (ram_wren),
    .ram_rdAddr (ram_rdAddr),
    .ram_rden   (ram_rden),
    .ram_dataout(ram_dataout),
    .fill_level (fill_level)
  );

  // Behavioural BRAM: three read registers that advance only on rden
  logic [W-1:0] mem [1 << AW];
  logic [W-1:0] r0, r1, r2;
  always @(posedge clk) begin
    if (ram_wren) mem[ram_wrAddr] <= ram_datain;
    if (ram_rden) begin
      r0 <= mem[ram_rdAddr];
      r1 <= r0;
      r2 <= r1;
    end
  end
  assign ram_dataout = r2;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [W-1:0] q[$];
  int wcnt = 0;
  int icnt = 0;
  int nout = 0;

  always @(negedge clk) begin
    int mfill;
    if (!rst_n) begin
      q.delete();
      wcnt = 0;
      icnt = 0;
      nout = 0;
    end else begin
      mfill = wcnt - icnt;
      check_eq("fill_level", 32'(fill_level), 32'(mfill));
      check_eq("s_ready", 32'(s_ready), 32'(mfill != DEPTH));
      check_eq("wren", 32'(ram_wren), 32'(s_valid && s_ready));
      if (q.size() == 0) check_eq("m_valid_idle", 32'(m_valid), 32'd0);
      if (m_valid && m_ready && q.size() != 0) begin
        check_eq("m_data", 32'(m_data), 32'(q.pop_front()));
        nout++;
      end
      if (s_valid && s_ready) begin
        check_eq("wr_addr", 32'(ram_wrAddr), 32'(wcnt % DEPTH));
        check_eq("datain", 32'(ram_datain), 32'(s_data));
        q.push_back(s_data);
        wcnt++;
      end
      if (ram_rden && mfill != 0) begin
        check_eq("rd_addr", 32'(ram_rdAddr), 32'(icnt % DEPTH));
        icnt++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_fill", 32'(fill_level), 32'd0);
    check_eq("rst_s_ready", 32'(s_ready), 32'd1);
    check_eq("rst_wren", 32'(ram_wren), 32'd0);
    check_eq("rst_rden", 32'(ram_rden), 32'd0);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // mode 0: counting data, m_ready toggles; 1: random data/m_ready;
  // 2: counting data, s_valid held high, m_ready low
  task automatic send_words(input int n, input int mode);
    int   idx = 0;
    int   budget = 0;
    logic acc;
    @(posedge clk); #1;
    s_data  = (mode == 1) ? W'($urandom) : W'(idx);
    s_valid = 1'b1;
    while (idx < n && budget < 5000) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      budget++;
      if (acc) begin
        idx++;
        s_data = (mode == 1) ? W'($urandom) : W'(idx);
      end
      s_valid = (idx < n) && (mode == 2 || $urandom_range(0, 9) < 8);
      case (mode)
        0:       m_ready = ~m_ready;
        1:       m_ready = ($urandom_range(0, 1) == 1);
        default: m_ready = 1'b0;
      endcase
    end
    s_valid = 1'b0;
    check_eq("send_done", 32'(idx), 32'(n));
  endtask

  task automatic drain();
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !m_valid && !ram_rden) break;
    end
    check_eq("drain_q", 32'(q.size()), 32'd0);
    check_eq("drain_m_valid", 32'(m_valid), 32'd0);
  endtask

  initial begin
    logic [9:0] mv_pat;
    logic [9:0] rd_pat;
    logic [W-1:0] burst [3];
    burst[0] = 16'h11;
    burst[1] = 16'h22;
    burst[2] = 16'h33;

    // Three-word burst: first m_valid 4 clocks after first write, then 3 in a row
    do_reset();
    @(posedge clk); #1;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = burst[0];
    mv_pat  = '0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      if (e < 2) s_data = burst[e + 1];
      else s_valid = 1'b0;
      @(negedge clk);
      mv_pat[e] = m_valid;
    end
    check_eq("burst_m_valid_pattern", 32'(mv_pat), 32'b0001110000);
    check_eq("burst_count", 32'(nout), 32'd3);

    // Single write then idle: rden high for exactly 4 cycles, m_valid holds
    do_reset();
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 16'h5A;
    mv_pat  = '0;
    rd_pat  = '0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(negedge clk);
      mv_pat[e] = m_valid;
      rd_pat[e] = ram_rden;
    end
    check_eq("single_rden_pattern", 32'(rd_pat), 32'b0000001111);
    check_eq("single_m_valid_pattern", 32'(mv_pat), 32'b1111110000);
    check_eq("single_m_data", 32'(m_data), 32'h5A);
    drain();
    check_eq("single_count", 32'(nout), 32'd1);

    // Capacity: BRAM depth + skid + 3 in-flight before s_ready drops
    do_reset();
    send_words(DEPTH + SKID + 3, 2);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("cap_accepted", 32'(wcnt), 32'(DEPTH + SKID + 3));
    check_eq("cap_fill", 32'(fill_level), 32'(DEPTH));
    check_eq("cap_s_ready", 32'(s_ready), 32'd0);
    drain();
    check_eq("cap_count", 32'(nout), 32'(DEPTH + SKID + 3));

    // Counting stream with m_ready toggling every cycle
    do_reset();
    send_words(100, 0);
    drain();
    check_eq("toggle_count", 32'(nout), 32'd100);

    // Random stream, random backpressure (wraps the BRAM pointers many times)
    do_reset();
    send_words(150, 1);
    drain();
    check_eq("random_count", 32'(nout), 32'd150);

    // Mid-stream reset discards buffered words; next write is the only output
    do_reset();
    send_words(6, 2);
    repeat (3) @(posedge clk);
    do_reset();
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 16'hAB;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    drain();
    check_eq("post_reset_count", 32'(nout), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
